// File: rtl/cassette_save.sv
// Streams a cassette (TAP) save image: quote bytes, header, RAM data read one
// byte at a time, checksum and trailer, over a valid/ready byte interface.
module cassette_save #(
    parameter int NAME_QUOTES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  file_type,
    input  logic [15:0] load_addr,
    input  logic [15:0] prog_len,
    input  logic [15:0] exec_addr,
    output logic [15:0] tape_addr,
    output logic        tape_rd,
    input  logic [7:0]  tape_din,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_RDREQ, S_RDWAIT, S_DATA, S_CHK, S_TRAIL, S_DONE
    } state_t;

    // Header is NAME_QUOTES quotes followed by seven fixed-position bytes.
    localparam logic [3:0] NQ       = 4'(NAME_QUOTES);
    localparam logic [3:0] HDR_LAST = 4'(NAME_QUOTES + 6);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  type_q, type_d;
    logic [15:0] len_q, len_d;
    logic [15:0] load_q, load_d;
    logic [15:0] exec_q, exec_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] remain_q, remain_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  sum_q, sum_d;
    logic        error_q, error_d;

    logic [3:0]  rel_idx;
    logic [15:0] len_p2;
    logic [7:0]  hdr_byte;

    assign rel_idx = idx_q - NQ;
    assign len_p2  = len_q + 16'd2;

    always_comb begin
        hdr_byte = 8'h22;
        if (idx_q >= NQ) begin
            case (rel_idx)
                4'd0:    hdr_byte = type_q;
                4'd1:    hdr_byte = len_p2[7:0];
                4'd2:    hdr_byte = len_p2[15:8];
                4'd3:    hdr_byte = load_q[7:0];
                4'd4:    hdr_byte = load_q[15:8];
                4'd5:    hdr_byte = exec_q[7:0];
                4'd6:    hdr_byte = exec_q[15:8];
                default: hdr_byte = 8'h00;
            endcase
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        idx_d     = idx_q;
        type_d    = type_q;
        len_d     = len_q;
        load_d    = load_q;
        exec_d    = exec_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        data_d    = data_q;
        sum_d     = sum_q;
        error_d   = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        tape_rd   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (prog_len > 16'hFFFD) begin
                        error_d = 1'b1;
                    end else begin
                        type_d   = file_type;
                        len_d    = prog_len;
                        load_d   = load_addr;
                        exec_d   = exec_addr;
                        addr_d   = load_addr;
                        remain_d = prog_len;
                        idx_d    = 4'd0;
                        sum_d    = 8'h00;
                        state_d  = S_HDR;
                    end
                end
            end
            S_HDR: begin
                out_valid = 1'b1;
                out_data  = hdr_byte;
                if (out_ready) begin
                    if (idx_q == HDR_LAST) begin
                        state_d = (remain_q != 16'd0) ? S_RDREQ : S_CHK;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_RDREQ: begin
                tape_rd = 1'b1;
                state_d = S_RDWAIT;
            end
            S_RDWAIT: begin
                data_d  = tape_din;
                state_d = S_DATA;
            end
            S_DATA: begin
                out_valid = 1'b1;
                out_data  = data_q;
                if (out_ready) begin
                    sum_d    = sum_q + data_q;
                    addr_d   = addr_q + 16'd1;
                    remain_d = remain_q - 16'd1;
                    state_d  = (remain_q == 16'd1) ? S_CHK : S_RDREQ;
                end
            end
            S_CHK: begin
                out_valid = 1'b1;
                out_data  = sum_q;
                if (out_ready) state_d = S_TRAIL;
            end
            S_TRAIL: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            type_q   <= 8'h00;
            len_q    <= 16'h0000;
            load_q   <= 16'h0000;
            exec_q   <= 16'h0000;
            addr_q   <= 16'h0000;
            remain_q <= 16'h0000;
            data_q   <= 8'h00;
            sum_q    <= 8'h00;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            type_q   <= type_d;
            len_q    <= len_d;
            load_q   <= load_d;
            exec_q   <= exec_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            data_q   <= data_d;
            sum_q    <= sum_d;
            error_q  <= error_d;
        end
    end

    assign tape_addr = addr_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign error     = error_q;

endmodule

// File: doc/cassette_save.md
CASSETTE_SAVE -- requirements
Module: cassette_save

Interface
REQ-001 The module SHALL have parameter NAME_QUOTES, default 2, giving the number of 0x22 bytes emitted before the file type.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to begin a save; honoured only in IDLE.
REQ-005 file_type  input  8  file type byte (0x42 = "B"); captured on accepted start.
REQ-006 load_addr  input  16  first RAM address to save; captured on accepted start.
REQ-007 prog_len  input  16  number of program bytes; captured on accepted start.
REQ-008 exec_addr  input  16  execution address; captured on accepted start.
REQ-009 tape_addr  output  16  RAM read address.
REQ-010 tape_rd  output  1  RAM read strobe, one cycle per byte.
REQ-011 tape_din  input  8  RAM read data, valid exactly one cycle after tape_rd.
REQ-012 out_data  output  8  TAP byte stream.
REQ-013 out_valid  output  1  out_data holds a byte.
REQ-014 out_ready  input  1  sink accepts the byte when out_valid and out_ready are both high.
REQ-015 busy  output  1  high from accepted start until DONE.
REQ-016 done  output  1  one-cycle pulse after the trailer byte is accepted.
REQ-017 error  output  1  one-cycle pulse on a rejected start.

Function
REQ-018 Byte order SHALL be: NAME_QUOTES x 0x22, file_type, LEN lo, LEN hi, load_addr lo, load_addr hi, exec_addr lo, exec_addr hi, prog_len data bytes, checksum, trailer 0x00.
REQ-019 LEN SHALL equal prog_len + 2 (16-bit).
REQ-020 A start with prog_len > 0xFFFD SHALL be rejected: error pulses the next cycle, the module stays IDLE, and nothing is emitted.
REQ-021 States: IDLE, HDR (quote, type, length, load and exec bytes, indexed by a 4-bit counter), RDREQ, RDWAIT, DATA, CHK, TRAIL, DONE.
REQ-022 Transitions: IDLE->HDR on accepted start; HDR->RDREQ after exec hi is accepted if prog_len != 0, else HDR->CHK; RDREQ->RDWAIT->DATA; DATA->RDREQ on accept if bytes remain, else DATA->CHK; CHK->TRAIL on accept; TRAIL->DONE on accept; DONE->IDLE after one cycle.
REQ-023 RDREQ SHALL assert tape_rd for one cycle with tape_addr = current address; RDWAIT SHALL latch tape_din into out_data.
REQ-024 The address SHALL increment by 1 per data byte and wrap 0xFFFF->0x0000.
REQ-025 checksum SHALL be the 8-bit sum, modulo 256, of all data bytes; it is 0x00 when prog_len = 0.
REQ-026 out_valid SHALL be high only in HDR, DATA, CHK and TRAIL.
REQ-027 While out_valid is high and out_ready is low, out_data and the state SHALL hold stable.
REQ-028 Acceptance of one byte SHALL take a single cycle; out_valid drops for exactly 2 cycles (RDREQ, RDWAIT) between consecutive data bytes and never between header bytes.
REQ-029 start SHALL be ignored while busy.
REQ-030 tape_rd SHALL never assert outside RDREQ.

Reset
REQ-031 On reset_n low, at any time including mid-transfer, the module SHALL immediately return to IDLE with tape_addr=0, tape_rd=0, out_data=0, out_valid=0, busy=0, done=0, error=0, checksum=0.
REQ-032 After reset_n rises, the first accepted start SHALL produce a complete stream from the first quote.

Verification
REQ-033 Scenario: NAME_QUOTES=2, start with type 0x42, load 0x694D, len 3, exec 0x6A00, RAM {0x01,0x02,0x03}, out_ready=1 -> stream 22 22 42 05 00 4D 69 00 6A 01 02 03 06 00, then done pulses.
REQ-034 Scenario: prog_len=0 -> stream 22 22 42 02 00 lo hi lo hi 00 00, with no tape_rd.
REQ-035 Scenario: load 0xFFFF, len 2 -> tape_addr sequence 0xFFFF then 0x0000.
REQ-036 Scenario: out_ready toggled randomly -> same byte sequence as REQ-033, and out_data stable whenever stalled.
REQ-037 Scenario: prog_len=0xFFFE -> error pulse, busy stays 0; reset_n pulsed mid-data -> all outputs reset, and a new start produces a correct stream.
